// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu -- multiply/divide unit of the Execute stage.
//
// Executes mult, multu, div, divu (multi-cycle) and mthi/mtlo (single cycle)
// and owns the architectural HI/LO registers. The result of a mult/div is
// computed combinationally from the operands presented on the start edge and
// parked in temp registers. It is committed to HI/LO on the last busy edge,
// so the pipeline observes the configured latency.
//
// Parameters:
//   MULT_CYCLES  cycles Busy stays high for mult/multu (>= 1)
//   DIV_CYCLES   cycles Busy stays high for div/divu   (>= 1)
//
// Ports:
//   Clk    in   clock, rising edge
//   Rst    in   asynchronous active-low reset
//   Start  in   E-stage instruction is md-class; qualifies MDOp
//   MDOp   in   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A      in   rs operand
//   B      in   rt operand
//   Busy   out  multi-cycle operation in progress
//   HI     out  HI register
//   LO     out  LO register
// ---------------------------------------------------------------------------
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t         state_reg;
    logic           busy_reg;
    logic [CW-1:0]  count_reg;
    logic [31:0]    hi_reg;
    logic [31:0]    lo_reg;
    logic [31:0]    tmp_hi_reg;
    logic [31:0]    tmp_lo_reg;
    logic           commit_reg;   // cleared for divide-by-zero: HI/LO untouched

    // Combinational results from the live operands; sampled only on start.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] divu_q;
    logic [31:0] divu_r;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    always_comb begin
        div_q  = '0;
        div_r  = '0;
        divu_q = '0;
        divu_r = '0;
        if (B != 32'd0) begin
            divu_q = A / B;
            divu_r = A % B;
            // The most-negative / -1 quotient overflows 32 bits; pin it to
            // the wrapped value instead of relying on the simulator/synth.
            if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                div_q = 32'h8000_0000;
                div_r = 32'd0;
            end else begin
                div_q = $signed(A) / $signed(B);
                div_r = $signed(A) % $signed(B);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg  <= ST_IDLE;
            busy_reg   <= 1'b0;
            count_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            tmp_hi_reg <= '0;
            tmp_lo_reg <= '0;
            commit_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            OP_MULT: begin
                                state_reg  <= ST_BUSY;
                                busy_reg   <= 1'b1;
                                count_reg  <= CW'(MULT_CYCLES);
                                tmp_hi_reg <= prod_s[63:32];
                                tmp_lo_reg <= prod_s[31:0];
                                commit_reg <= 1'b1;
                            end
                            OP_MULTU: begin
                                state_reg  <= ST_BUSY;
                                busy_reg   <= 1'b1;
                                count_reg  <= CW'(MULT_CYCLES);
                                tmp_hi_reg <= prod_u[63:32];
                                tmp_lo_reg <= prod_u[31:0];
                                commit_reg <= 1'b1;
                            end
                            OP_DIV: begin
                                state_reg  <= ST_BUSY;
                                busy_reg   <= 1'b1;
                                count_reg  <= CW'(DIV_CYCLES);
                                tmp_hi_reg <= div_r;
                                tmp_lo_reg <= div_q;
                                commit_reg <= (B != 32'd0);
                            end
                            OP_DIVU: begin
                                state_reg  <= ST_BUSY;
                                busy_reg   <= 1'b1;
                                count_reg  <= CW'(DIV_CYCLES);
                                tmp_hi_reg <= divu_r;
                                tmp_lo_reg <= divu_q;
                                commit_reg <= (B != 32'd0);
                            end
                            OP_MTHI: hi_reg <= A;
                            OP_MTLO: lo_reg <= A;
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    // All new requests are ignored here; the hazard unit
                    // never issues them, so nothing needs to be queued.
                    if (count_reg == CW'(1)) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        count_reg <= '0;
                        if (commit_reg) begin
                            hi_reg <= tmp_hi_reg;
                            lo_reg <= tmp_lo_reg;
                        end
                    end else begin
                        count_reg <= count_reg - CW'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------
// tb_e_mdu -- self-checking bench for e_mdu.
// Expected HI/LO results are pushed to a scoreboard queue when an operation
// is issued and popped when the DUT drops Busy (or after a move completes).
// Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .Clk   (clk),
        .Rst   (rst),
        .Start (start),
        .MDOp  (md_op),
        .A     (a),
        .B     (b),
        .Busy  (busy),
        .HI    (hi),
        .LO    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_cnt++;
        if (obs !== expv) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, expv);
        end
    endtask

    // Issue a multi-cycle op; optionally inject another request at busy
    // cycle inj_cycle (0 = none). A/B are scrambled after the start edge.
    task automatic run_md(input string tag, input logic [2:0] op,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int n, input int inj_cycle,
                          input logic [2:0] inj_op, input logic [31:0] inj_val);
        int cnt;
        logic [63:0] e;
        @(negedge clk);
        start = 1'b1; md_op = op; a = av; b = bv;
        exp_q.push_back({eh, el});
        @(negedge clk);
        start = 1'b0; md_op = 3'd0; a = $urandom; b = $urandom;
        cnt = 0;
        while (busy && cnt < 50) begin
            check_val({tag, "_hold"}, {hi, lo}, {model_hi, model_lo});
            cnt++;
            if (cnt == inj_cycle) begin
                start = 1'b1; md_op = inj_op; a = inj_val;
            end else begin
                start = 1'b0; md_op = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0; md_op = 3'd0;
        check_val({tag, "_busylen"}, 64'(cnt), 64'(n));
        e = exp_q.pop_front();
        check_val({tag, "_hilo"}, {hi, lo}, e);
        model_hi = e[63:32];
        model_lo = e[31:0];
        $display("txn %s: op=%0d A=%08h B=%08h busy=%0d HI=%08h LO=%08h", tag, op, av, bv, cnt, hi, lo);
    endtask

    // Single-cycle move (or a no-op request): expected values via scoreboard.
    task automatic run_mv(input string tag, input logic [2:0] op, input logic [31:0] av,
                          input logic [31:0] eh, input logic [31:0] el);
        logic [63:0] e;
        @(negedge clk);
        start = 1'b1; md_op = op; a = av; b = $urandom;
        exp_q.push_back({eh, el});
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        e = exp_q.pop_front();
        check_val({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check_val({tag, "_hilo"}, {hi, lo}, e);
        model_hi = e[63:32];
        model_lo = e[31:0];
        $display("txn %s: op=%0d A=%08h HI=%08h LO=%08h", tag, op, av, hi, lo);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; md_op = 3'd0; a = '0; b = '0;
        model_hi = '0; model_lo = '0;

        // Reset state, then idle cycles with no change.
        #12;
        check_val("rst_state", {31'd0, busy, hi, lo}, 65'd0);
        @(negedge clk); rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("idle_state", {31'd0, busy, hi, lo}, 65'd0);
        end
        $display("txn reset: busy=%0d HI=%08h LO=%08h", busy, hi, lo);

        run_mv("mthi", 3'd5, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000);
        run_mv("mtlo", 3'd6, 32'hCAFE_BABE, 32'h1234_5678, 32'hCAFE_BABE);

        run_md("mult",  3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MC, 0, 3'd0, 32'd0);
        run_md("multu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, MC, 0, 3'd0, 32'd0);
        run_md("div_neg", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC, 0, 3'd0, 32'd0);
        run_md("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DC, 0, 3'd0, 32'd0);

        run_mv("mthi2", 3'd5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h8000_0000);
        run_md("divu_z", 3'd4, 32'd7, 32'd0, 32'hA5A5_A5A5, 32'h8000_0000, DC, 0, 3'd0, 32'd0);

        // Requests while busy must be ignored.
        run_md("divu_mtlo", 3'd4, 32'd7, 32'd2, 32'd1, 32'd3, DC, 3, 3'd6, 32'hDEAD_BEEF);
        run_md("divu_mult", 3'd4, 32'd20, 32'd6, 32'd2, 32'd3, DC, 5, 3'd1, 32'h0000_0009);

        // Start with a none/reserved op has no effect.
        run_mv("op0", 3'd0, 32'h5555_5555, 32'd2, 32'd3);
        run_mv("op7", 3'd7, 32'h6666_6666, 32'd2, 32'd3);

        // Reset mid-operation aborts asynchronously.
        @(negedge clk);
        start = 1'b1; md_op = 3'd4; a = 32'd100; b = 32'd3;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        repeat (3) @(negedge clk);
        check_val("abort_busy_pre", {63'd0, busy}, 64'd1);
        #2 rst = 1'b0;
        #1;
        check_val("abort_state", {31'd0, busy, hi, lo}, 65'd0);
        $display("txn abort: busy=%0d HI=%08h LO=%08h", busy, hi, lo);
        @(negedge clk); rst = 1'b1;
        model_hi = '0; model_lo = '0;

        run_md("mult_post", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12, MC, 0, 3'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
